// File: rtl/conv_filter_seq.sv
// rtl/conv_filter_seq.sv - sequential strided multi-channel 2-D valid convolution, one MAC per cycle
//
// Purpose:
//   Captures a snapshot of a flat filter and a flat input feature map on start.
//   Then computes every output window with one signed fixed-point multiply-accumulate per cycle.
//   Each finished pixel is streamed out over a valid/ready handshake, in raster order.
//
// Optional build macro: CONV_FILTER_SEQ_RELU_EN
//   When defined, negative saturated results are clamped to zero before output.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   begin a job (sampled only while idle)
//   filter_data  in   C*F*F words, element (c,r,k) at word c*F*F + r*F + k
//   input_data   in   C*I*I words, element (c,r,k) at word c*I*I + r*I + k
//   out_data     out  result pixel
//   out_row      out  output row of out_data
//   out_col      out  output column of out_data
//   out_valid    out  out_data/out_row/out_col valid
//   out_ready    in   downstream accepts the pixel
//   busy         out  a job is in progress
//   done         out  one-cycle pulse after the final pixel is accepted

module conv_filter_seq #(
  parameter int DATA_W      = 32,
  parameter int FRAC_W      = 15,
  parameter int INPUT_SIZE  = 7,
  parameter int FILTER_SIZE = 5,
  parameter int STRIDE      = 2,
  parameter int CHANNELS    = 1,
  parameter logic signed [DATA_W-1:0] BIAS = '0,
  localparam int OUT_SIZE   = (INPUT_SIZE - FILTER_SIZE) / STRIDE + 1,
  localparam int K          = CHANNELS * FILTER_SIZE * FILTER_SIZE,
  localparam int RC_W       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [K*DATA_W-1:0]                    filter_data,
  input  logic [CHANNELS*INPUT_SIZE*INPUT_SIZE*DATA_W-1:0] input_data,
  output logic [DATA_W-1:0]                      out_data,
  output logic [RC_W-1:0]                        out_row,
  output logic [RC_W-1:0]                        out_col,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy,
  output logic                                   done
);

  localparam int FF     = FILTER_SIZE * FILTER_SIZE;
  localparam int II     = INPUT_SIZE * INPUT_SIZE;
  localparam int NIN    = CHANNELS * II;
  localparam int FI_W   = (K > 1) ? $clog2(K) : 1;
  localparam int II_W   = (NIN > 1) ? $clog2(NIN) : 1;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int F_W    = (FILTER_SIZE > 1) ? $clog2(FILTER_SIZE) : 1;
  localparam int P_W    = 2 * DATA_W;
  localparam int ACC_W  = 2 * DATA_W + $clog2(K) + 1;
  // One spare bit so adding the shifted bias can never wrap.
  localparam int SUM_W  = ACC_W + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'({1'b0, {(DATA_W-1){1'b1}}});
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    FIN  = 2'd2,
    EMIT = 2'd3
  } state_t;

  state_t                    state_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [CH_W-1:0]           ch_q;
  logic [F_W-1:0]            fr_q;
  logic [F_W-1:0]            fc_q;
  logic [RC_W-1:0]           wr_q;
  logic [RC_W-1:0]           wc_q;
  logic                      last_q;
  logic [DATA_W-1:0]         out_data_q;
  logic [RC_W-1:0]           out_row_q;
  logic [RC_W-1:0]           out_col_q;
  logic                      out_valid_q;
  logic                      busy_q;
  logic                      done_q;

  logic signed [DATA_W-1:0]  filt_q [K];
  logic signed [DATA_W-1:0]  inp_q  [NIN];

  logic [FI_W-1:0]           f_idx;
  logic [II_W-1:0]           i_idx;
  logic signed [DATA_W-1:0]  f_word;
  logic signed [DATA_W-1:0]  i_word;
  logic signed [P_W-1:0]     f_ext;
  logic signed [P_W-1:0]     i_ext;
  logic signed [P_W-1:0]     prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic                      tap_last;
  logic [CH_W-1:0]           ch_d;
  logic [F_W-1:0]            fr_d;
  logic [F_W-1:0]            fc_d;
  logic [RC_W-1:0]           wr_d;
  logic [RC_W-1:0]           wc_d;
  logic                      win_last;
  logic signed [SUM_W-1:0]   bias_ext;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   shifted;
  logic signed [DATA_W-1:0]  sat;
  logic [DATA_W-1:0]         result;

  // Tap address and product for the current (channel, filter row, filter column, window).
  always_comb begin
    f_idx    = FI_W'(int'(ch_q) * FF + int'(fr_q) * FILTER_SIZE + int'(fc_q));
    i_idx    = II_W'(int'(ch_q) * II
                     + (int'(wr_q) * STRIDE + int'(fr_q)) * INPUT_SIZE
                     + int'(wc_q) * STRIDE + int'(fc_q));
    f_word   = filt_q[f_idx];
    i_word   = inp_q[i_idx];
    f_ext    = {{DATA_W{f_word[DATA_W-1]}}, f_word};
    i_ext    = {{DATA_W{i_word[DATA_W-1]}}, i_word};
    prod     = f_ext * i_ext;
    prod_ext = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
  end

  // Tap walk: column fastest, then row, then channel; wraps to zero after the last tap.
  always_comb begin
    ch_d     = ch_q;
    fr_d     = fr_q;
    fc_d     = fc_q;
    tap_last = (fc_q == F_W'(FILTER_SIZE - 1)) && (fr_q == F_W'(FILTER_SIZE - 1))
               && (ch_q == CH_W'(CHANNELS - 1));
    if (fc_q != F_W'(FILTER_SIZE - 1)) begin
      fc_d = fc_q + F_W'(1);
    end else begin
      fc_d = '0;
      if (fr_q != F_W'(FILTER_SIZE - 1)) begin
        fr_d = fr_q + F_W'(1);
      end else begin
        fr_d = '0;
        ch_d = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + CH_W'(1);
      end
    end
  end

  // Window walk in raster order.
  always_comb begin
    wr_d     = wr_q;
    wc_d     = wc_q;
    win_last = (wr_q == RC_W'(OUT_SIZE - 1)) && (wc_q == RC_W'(OUT_SIZE - 1));
    if (wc_q != RC_W'(OUT_SIZE - 1)) begin
      wc_d = wc_q + RC_W'(1);
    end else begin
      wc_d = '0;
      wr_d = (wr_q == RC_W'(OUT_SIZE - 1)) ? '0 : wr_q + RC_W'(1);
    end
  end

  // Finalise: add bias at full product scale, floor-shift back to FRAC_W, saturate.
  always_comb begin
    bias_ext = {{(SUM_W-DATA_W){BIAS[DATA_W-1]}}, BIAS};
    sum      = {acc_q[ACC_W-1], acc_q} + (bias_ext <<< FRAC_W);
    shifted  = sum >>> FRAC_W;
    if (shifted > SAT_MAX) begin
      sat = SAT_MAX[DATA_W-1:0];
    end else if (shifted < SAT_MIN) begin
      sat = SAT_MIN[DATA_W-1:0];
    end else begin
      sat = shifted[DATA_W-1:0];
    end
`ifdef CONV_FILTER_SEQ_RELU_EN
    result = sat[DATA_W-1] ? '0 : sat;
`else
    result = sat;
`endif
  end

  // Operand snapshot; plain data storage, so no reset is needed.
  always_ff @(posedge clk) begin
    if (!rst && state_q == IDLE && start) begin
      for (int i = 0; i < K; i++) begin
        filt_q[i] <= filter_data[i*DATA_W +: DATA_W];
      end
      for (int i = 0; i < NIN; i++) begin
        inp_q[i] <= input_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ch_q        <= '0;
      fr_q        <= '0;
      fc_q        <= '0;
      wr_q        <= '0;
      wc_q        <= '0;
      last_q      <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            acc_q   <= '0;
            ch_q    <= '0;
            fr_q    <= '0;
            fc_q    <= '0;
            wr_q    <= '0;
            wc_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= MAC;
          end
        end
        MAC: begin
          acc_q <= acc_q + prod_ext;
          ch_q  <= ch_d;
          fr_q  <= fr_d;
          fc_q  <= fc_d;
          if (tap_last) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          out_data_q  <= result;
          out_row_q   <= wr_q;
          out_col_q   <= wc_q;
          out_valid_q <= 1'b1;
          last_q      <= win_last;
          // Step to the next window now so the handshake edge can already
          // fetch its first tap.
          wr_q        <= wr_d;
          wc_q        <= wc_d;
          state_q     <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (last_q) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              // Clearing the accumulator and taking tap 0 of the next window
              // happen together, keeping one pixel every K+1 cycles.
              acc_q   <= prod_ext;
              ch_q    <= ch_d;
              fr_q    <= fr_d;
              fc_q    <= fc_d;
              state_q <= (K == 1) ? FIN : MAC;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_col   = out_col_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_conv_filter_seq.sv
// tb/tb_conv_filter_seq.sv - directed self-checking bench for conv_filter_seq

module tb_conv_filter_seq;

  localparam int DW = 32;
  localparam int KP1 = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, start, start2, out_ready;
  logic [25*DW-1:0]   filt;
  logic [49*DW-1:0]   inp;
  logic [50*DW-1:0]   filt2;
  logic [98*DW-1:0]   inp2;
  logic [DW-1:0]      out_data, out_data2;
  logic               out_row, out_col, out_valid, busy, done;
  logic               out_row2, out_col2, out_valid2, busy2, done2;

  int vecs = 0;
  int errs = 0;
  int d2_pix = 0;
  int d2_done = 0;

  conv_filter_seq u_dut (
    .clk(clk), .rst(rst), .start(start), .filter_data(filt), .input_data(inp),
    .out_data(out_data), .out_row(out_row), .out_col(out_col), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  conv_filter_seq #(.CHANNELS(2), .BIAS(32'h0000_8000)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .filter_data(filt2), .input_data(inp2),
    .out_data(out_data2), .out_row(out_row2), .out_col(out_col2), .out_valid(out_valid2),
    .out_ready(1'b1), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [25*DW-1:0] mk_f(input logic [DW-1:0] odd, input logic [DW-1:0] even);
    logic [25*DW-1:0] v;
    for (int i = 0; i < 25; i++) v[i*DW +: DW] = (i % 2 == 1) ? odd : even;
    return v;
  endfunction

  function automatic logic [49*DW-1:0] mk_i(input logic [DW-1:0] odd, input logic [DW-1:0] even);
    logic [49*DW-1:0] v;
    for (int i = 0; i < 49; i++) v[i*DW +: DW] = (i % 2 == 1) ? odd : even;
    return v;
  endfunction

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Collects pixels (ready high) from first_pix onward until done; cycles counted from the start edge.
  task automatic collect(input string tag, input logic [DW-1:0] exp, input int first_pix, input bit chk_t);
    int cyc = 0;
    int pix = first_pix;
    int dn = 0;
    int last_v = 0;
    while (dn == 0 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) begin
        dn++;
        check({tag, "_pix_before_done"}, 64'(pix), 64'd4);
        if (chk_t) check({tag, "_done_cycle"}, 64'(cyc), 64'(last_v + 1));
      end
      if (out_valid) begin
        check({tag, "_data"}, 64'(out_data), 64'(exp));
        check({tag, "_row"}, 64'(out_row), 64'(pix / 2));
        check({tag, "_col"}, 64'(out_col), 64'(pix % 2));
        if (chk_t) check({tag, "_valid_cycle"}, 64'(cyc), 64'(KP1 * (pix + 1)));
        last_v = cyc;
        pix++;
      end
    end
    check({tag, "_done_seen"}, 64'(dn), 64'd1);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  // Second instance: 2 channels of the parity pattern (24.0) plus bias 1.0.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (out_valid2) begin
        check("ch2_bias_data", 64'(out_data2), 64'h0000_0000_000C_8000);
        check("ch2_row", 64'(out_row2), 64'(d2_pix / 2));
        check("ch2_col", 64'(out_col2), 64'(d2_pix % 2));
        d2_pix++;
      end
      if (done2) d2_done++;
    end
  end

  initial begin
    logic [DW-1:0] exp_neg, exp_nsat;
    int cyc;
    int bad;
`ifdef CONV_FILTER_SEQ_RELU_EN
    exp_neg  = 32'h0000_0000;
    exp_nsat = 32'h0000_0000;
`else
    exp_neg  = 32'hFFF3_8000;
    exp_nsat = 32'h8000_0000;
`endif
    rst = 1'b1; start = 1'b0; start2 = 1'b0; out_ready = 1'b1;
    filt  = mk_f(32'h0000_8000, 32'h0);
    inp   = mk_i(32'h0000_8000, 32'h0);
    filt2 = {filt, filt};
    inp2  = {inp, inp};
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_row", 64'(out_row), 64'd0);
    check("rst_col", 64'(out_col), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Parity pattern: 12 non-zero taps per window -> 12.0.
    @(negedge clk);
    start = 1'b1; start2 = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; start2 = 1'b0;
    check("par_busy", 64'(busy), 64'd1);
    collect("par", 32'h0006_0000, 0, 1'b1);

    // -1.0 * 1.0 over 25 taps.
    filt = mk_f(32'hFFFF_8000, 32'hFFFF_8000);
    inp  = mk_i(32'h0000_8000, 32'h0000_8000);
    kick();
    collect("neg", exp_neg, 0, 1'b1);

    filt = mk_f(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    inp  = mk_i(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    kick();
    collect("psat", 32'h7FFF_FFFF, 0, 1'b0);

    filt = mk_f(32'h8000_0000, 32'h8000_0000);
    kick();
    collect("nsat", exp_nsat, 0, 1'b0);

    // Back-pressure with input churn and start pulses during the hold.
    filt = mk_f(32'h0000_8000, 32'h0);
    inp  = mk_i(32'h0000_8000, 32'h0);
    out_ready = 1'b0;
    kick();
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("hold_first_valid_cycle", 64'(cyc), 64'(KP1));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      inp   = ~inp;
      start = (i % 2 == 0);
      @(posedge clk);
      #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(out_data), 64'h0006_0000);
      check("hold_rowcol", 64'({out_row, out_col}), 64'd0);
      check("hold_busy", 64'(busy), 64'd1);
    end
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b1;
    collect("hold", 32'h0006_0000, 1, 1'b0);
    bad = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (busy || out_valid) bad++;
    end
    check("hold_no_second_job", 64'(bad), 64'd0);

    // Reset in the middle of the second window.
    inp = mk_i(32'h0000_8000, 32'h0);
    kick();
    repeat (38) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_outputs", 64'({out_data, out_row, out_col, out_valid, busy, done}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done || out_valid || busy) bad++;
    end
    check("mid_rst_quiet", 64'(bad), 64'd0);
    kick();
    collect("rerun", 32'h0006_0000, 0, 1'b1);

    check("ch2_pixels", 64'(d2_pix), 64'd4);
    check("ch2_done", 64'(d2_done), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
